// File: rtl/ram_ctrl_sync.sv
// Single-port synchronous RAM behind a req/ack handshake.
// Supports programmable wait states and an optional zero-fill sweep after reset.
module ram_ctrl_sync #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int WAIT_STATES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_writeNEn,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_writeData,
    input  logic                  i_noe,
    output logic [DATA_WIDTH-1:0] o_readData,
    output logic                  o_ack,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d;
    logic                  capture;

    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  ack_q;
    logic                  busy_q;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        clr_d   = clr_q;
        capture = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_d = clr_q + ADDR_WIDTH'(1);
                if (clr_q == '1) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (i_req) begin
                    capture = 1'b1;
                    wait_d  = WAIT_LOAD;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The zero-fill sweep and committed writes share the single memory port.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_q;
            mem_wdata = '0;
        end else if (state_q == S_ACK && !wen_q) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            busy_q  <= (CLEAR_ON_RESET != 0);
            wait_q  <= '0;
            clr_q   <= '0;
            ack_q   <= 1'b0;
            rd_q    <= '0;
            wen_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            ack_q   <= (state_d == S_ACK);
            wait_q  <= wait_d;
            clr_q   <= clr_d;
            if (capture) begin
                wen_q   <= i_writeNEn;
                addr_q  <= i_address;
                wdata_q <= i_writeData;
            end
            if (state_q == S_ACK && wen_q) begin
                rd_q <= mem[addr_q];
            end
        end
    end

    // Reset blocks the commit so an access abandoned in ACK leaves memory intact.
    always_ff @(posedge i_clk) begin
        if (!i_rst && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign o_readData = rd_q & {DATA_WIDTH{~i_noe}};
    assign o_ack      = ack_q;
    assign o_busy     = busy_q;

endmodule
